int_adder_arb: RTL and testbench
================================

Name: int_adder_arb

Overview:
- Round-robin arbiter and scheduler that shares one `int_adder_comb` datapath between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The winner's operands are added, and the result is captured in a single output register.
- The result is returned on a valid/ready output channel, tagged with the requester index. A saturating count of completed operations is kept.
- Sits between issue logic and the integer ALU result path.

Parameters:
- DATA_WIDTH, 32, operand and sum width.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester tag; minimum 1.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_data_a  input  NUM_REQ*DATA_WIDTH  packed operand A; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_data_b  input  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer accepts result.
- res_sum  output  DATA_WIDTH  registered sum.
- res_carry_out  output  1  registered carry out.
- res_id  output  ID_WIDTH  index of the requester that produced res_sum.
- op_count  output  CNT_WIDTH  completed result handshakes, saturating.

Behaviour:
- Reset (rst=1 at edge): res_valid=0, res_sum=0, res_carry_out=0, res_id=0, op_count=0, rr_ptr=0. req_ready is combinational and is 0 while res_valid=1 and res_ready=0.
- Reset mid-operation discards any held result. No handshake completes on a reset cycle.
- Define can_accept = !res_valid | res_ready.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit is the grant g.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready = 0.
- req_ready may depend on req_valid. Requesters must not make valid depend on ready. Operands must be held stable while valid and not accepted.
- Accept occurs when req_valid[g] & req_ready[g]. At that edge:
  - res_sum/res_carry_out load the adder output for operands g, with carry_in=0.
  - res_id is set to g and res_valid is set to 1.
  - rr_ptr becomes (g+1) mod NUM_REQ.
- Latency is 1 cycle from accept to res_valid. Throughput is one operation per cycle while res_ready=1.
- Output drain occurs when res_valid & res_ready. If there is no accept in the same cycle, res_valid becomes 0 and res_sum/res_carry_out/res_id hold their last values.
- Simultaneous drain and accept: the new result is loaded and res_valid stays 1, with no bubble.
- Backpressure (res_valid=1, res_ready=0):
  - All req_ready are 0 and rr_ptr is frozen.
  - res_* outputs are stable until drained.
- Arithmetic: {res_carry_out, res_sum} = A + B, (DATA_WIDTH+1)-bit unsigned. The sum wraps mod 2^DATA_WIDTH, and the carry reflects the overflow.
- op_count increments by 1 on each output drain and saturates at 2^CNT_WIDTH-1 (no wrap).
- No requester can be starved. A continuously valid requester is granted within NUM_REQ accepts.

Decomposition:
- Shared package int_alu_pkg:
  - localparams for the default DATA_WIDTH and CNT_WIDTH.
  - A function for the round-robin priority search (rr_ptr, req_valid -> g, found), reusable by later ALU arbiters.
- One sub-module instance: the existing `int_adder_comb` (DATA_WIDTH passed through), fed by a combinational mux on g.
- The arbiter logic stays inline in this module; no second sub-module.

Test Plan:
- Single requester: rst, then req_valid=4'b0100, A=32'h0000_0005, B=32'h0000_0003, res_ready=1 -> req_ready=4'b0100 the same cycle. Next cycle: res_valid=1, res_sum=8, res_carry_out=0, res_id=2, op_count=1 one cycle after drain.
- Overflow: A=32'hFFFF_FFFF, B=32'h0000_0001 -> res_sum=0, res_carry_out=1. A=32'h8000_0000, B=32'h8000_0000 -> res_sum=0, res_carry_out=1.
- Fairness: all four req_valid held high for 8 cycles with res_ready=1 -> res_id sequence 0,1,2,3,0,1,2,3, one result per cycle, no gaps.
- Backpressure: res_ready=0 for 5 cycles with requesters valid -> req_ready=0, res_* and rr_ptr unchanged. On res_ready=1, the held result drains and a new result loads the same edge, so res_valid never drops.
- Reset mid-op: rst=1 while res_valid=1 -> next cycle res_valid=0, op_count=0, rr_ptr=0. After release, requester 0 wins first when all are valid.
- Saturation (CNT_WIDTH=4 build): 20 drained results -> op_count stops at 15.

Source files
------------

// File: rtl/int_alu_pkg.sv
// -----------------------------------------------------------------------------
// int_alu_pkg
// Shared definitions for the integer ALU arbiters.
//   DEFAULT_DATA_WIDTH / DEFAULT_CNT_WIDTH : default datapath and counter widths
//   RR_MAX_REQ / RR_IDX_W                  : largest requester count the
//                                            round-robin search supports
//   rr_grant_t                             : result of the round-robin search
//   rr_search()                            : rotating-priority first-set search
// -----------------------------------------------------------------------------
package int_alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH  = 16;
    localparam int RR_MAX_REQ         = 16;
    localparam int RR_IDX_W           = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_grant_t;

    // Finds the first set bit of valid[n-1:0], starting at ptr and wrapping
    // n-1 -> 0. The loop runs from the farthest offset down to the nearest so
    // that the last hit written is the one closest to ptr.
    function automatic rr_grant_t rr_search(
        input logic [RR_IDX_W-1:0]   ptr,
        input logic [RR_MAX_REQ-1:0] valid,
        input int                    n
    );
        rr_grant_t r;
        int        idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx]) begin
                    r.found = 1'b1;
                    r.idx   = RR_IDX_W'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int_adder_comb.sv
// -----------------------------------------------------------------------------
// int_adder_comb
// Purely combinational unsigned adder with carry in/out.
//   a, b      : operands
//   carry_in  : carry into bit 0
//   sum       : a + b + carry_in, modulo 2^DATA_WIDTH
//   carry_out : carry out of the top bit
// -----------------------------------------------------------------------------
module int_adder_comb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/int_adder_arb.sv
// -----------------------------------------------------------------------------
// int_adder_arb
// Round-robin arbiter sharing one int_adder_comb between NUM_REQ requesters.
// The winner's sum is captured in a single result register and returned on a
// valid/ready channel tagged with the requester index.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid / req_ready   : per-requester handshake (ready is one-hot or 0)
//   req_data_a / req_data_b : packed operands, requester i at [i*DW +: DW]
//   res_valid / res_ready   : result handshake
//   res_sum, res_carry_out  : registered sum and carry
//   res_id                  : requester that produced the held result
//   op_count                : saturating count of drained results
// -----------------------------------------------------------------------------
module int_adder_arb
    import int_alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_b,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH-1:0]         res_sum,
    output logic                          res_carry_out,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic [CNT_WIDTH-1:0]          op_count
);

    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_sum_q, res_sum_d;
    logic                  res_carry_q, res_carry_d;
    logic [ID_WIDTH-1:0]   res_id_q, res_id_d;
    logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_carry;
    rr_grant_t             grant;
    logic [ID_WIDTH-1:0]   g_id;
    logic                  can_accept;
    logic                  accept;
    logic                  drain;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]     = req_data_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi]     = req_data_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = accept && (g_id == ID_WIDTH'(gi));
        end
    endgenerate

    assign grant      = rr_search(RR_IDX_W'(rr_ptr_q), RR_MAX_REQ'(req_valid), NUM_REQ);
    assign g_id       = grant.idx[ID_WIDTH-1:0];
    // The result slot is free if empty or being drained this cycle.
    assign can_accept = !res_valid_q || res_ready;
    // A found grant implies req_valid[g] is set, so accept needs no re-check.
    assign accept     = grant.found && can_accept;
    assign drain      = res_valid_q && res_ready;

    int_adder_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a         (a_arr[g_id]),
        .b         (b_arr[g_id]),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_carry_d = res_carry_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;

        if (drain) begin
            res_valid_d = 1'b0;
            if (op_count_q != {CNT_WIDTH{1'b1}}) begin
                op_count_d = op_count_q + CNT_WIDTH'(1);
            end
        end

        // Accept after drain so a same-cycle accept keeps res_valid high.
        if (accept) begin
            res_valid_d = 1'b1;
            res_sum_d   = add_sum;
            res_carry_d = add_carry;
            res_id_d    = g_id;
            if (g_id == ID_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = g_id + ID_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_carry_q <= res_carry_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res_valid     = res_valid_q;
    assign res_sum       = res_sum_q;
    assign res_carry_out = res_carry_q;
    assign res_id        = res_id_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_int_adder_arb.sv
// -----------------------------------------------------------------------------
// tb_int_adder_arb
// Directed bench for int_adder_arb. A second instance built with a 4-bit
// counter shares all inputs and is used to observe op_count saturation.
// -----------------------------------------------------------------------------
module tb_int_adder_arb;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_data_a;
    logic [NR*DW-1:0] req_data_b;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    res_sum;
    logic             res_carry_out;
    logic [IW-1:0]    res_id;
    logic [15:0]      op_count;

    logic [NR-1:0]    req_ready_s;
    logic             res_valid_s;
    logic [DW-1:0]    res_sum_s;
    logic             res_carry_out_s;
    logic [IW-1:0]    res_id_s;
    logic [3:0]       op_count_s;

    int total = 0;
    int bad   = 0;

    int_adder_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data_a(req_data_a), .req_data_b(req_data_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_carry_out(res_carry_out),
        .res_id(res_id), .op_count(op_count)
    );

    int_adder_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_s),
        .req_data_a(req_data_a), .req_data_b(req_data_b),
        .res_valid(res_valid_s), .res_ready(res_ready),
        .res_sum(res_sum_s), .res_carry_out(res_carry_out_s),
        .res_id(res_id_s), .op_count(op_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_data_a[i*DW +: DW] = a;
        req_data_b[i*DW +: DW] = b;
    endtask

    // Fairness operands: A_i = 0x1000*(i+1), B_i = i
    logic [DW-1:0] fair_sum [NR] = '{32'h0000_1000, 32'h0000_2001, 32'h0000_3002, 32'h0000_4003};

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_data_a = '0;
        req_data_b = '0;
        res_ready  = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum",   64'(res_sum),   64'd0);
        chk("rst_carry", 64'(res_carry_out), 64'd0);
        chk("rst_id",    64'(res_id),    64'd0);
        chk("rst_cnt",   64'(op_count),  64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Single requester 2: 5 + 3
        rst       = 1'b0;
        res_ready = 1'b1;
        set_op(2, 32'h0000_0005, 32'h0000_0003);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_sum",   64'(res_sum),   64'd8);
        chk("single_carry", 64'(res_carry_out), 64'd0);
        chk("single_id",    64'(res_id),    64'd2);
        chk("single_cnt0",  64'(op_count),  64'd0);
        step();
        chk("single_cnt1",  64'(op_count),  64'd1);
        chk("single_drained", 64'(res_valid), 64'd0);
        chk("single_hold_sum", 64'(res_sum), 64'd8);

        // Overflow: pointer is 3, requester 0 wins by wrapping
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0001;
        #1;
        chk("ovf0_ready", 64'(req_ready), 64'b0001);
        step();
        chk("ovf0_sum",   64'(res_sum), 64'd0);
        chk("ovf0_carry", 64'(res_carry_out), 64'd1);
        chk("ovf0_id",    64'(res_id), 64'd0);
        set_op(1, 32'h8000_0000, 32'h8000_0000);
        req_valid = 4'b0010;
        #1;
        chk("ovf1_ready", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        chk("ovf1_valid", 64'(res_valid), 64'd1);
        chk("ovf1_sum",   64'(res_sum), 64'd0);
        chk("ovf1_carry", 64'(res_carry_out), 64'd1);
        chk("ovf1_id",    64'(res_id), 64'd1);
        chk("ovf1_cnt",   64'(op_count), 64'd2);
        step();
        chk("ovf_cnt",    64'(op_count), 64'd3);

        // Requester 3 alone (pointer 2 -> 3), moves pointer to 0
        set_op(3, 32'd10, 32'd20);
        req_valid = 4'b1000;
        step();
        chk("r3_sum", 64'(res_sum), 64'd30);
        chk("r3_id",  64'(res_id),  64'd3);

        // Fairness: all valid, one result per cycle in order 0,1,2,3,...
        for (int i = 0; i < NR; i++) begin
            set_op(i, DW'(32'h1000 * (i + 1)), DW'(i));
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("fair%0d_valid", k), 64'(res_valid), 64'd1);
            chk($sformatf("fair%0d_id", k),    64'(res_id), 64'(k % NR));
            chk($sformatf("fair%0d_sum", k),   64'(res_sum), 64'(fair_sum[k % NR]));
        end
        chk("fair_cnt", 64'(op_count), 64'd11);

        // Backpressure: held result id 3 must not move, nothing granted
        res_ready = 1'b0;
        #1;
        chk("bp_ready0", 64'(req_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp%0d_valid", k), 64'(res_valid), 64'd1);
            chk($sformatf("bp%0d_id", k),    64'(res_id), 64'd3);
            chk($sformatf("bp%0d_sum", k),   64'(res_sum), 64'h4003);
            chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'd0);
        end
        chk("bp_cnt", 64'(op_count), 64'd11);
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b0001);
        step();
        chk("bp_release_valid", 64'(res_valid), 64'd1);
        chk("bp_release_id",    64'(res_id), 64'd0);
        chk("bp_release_sum",   64'(res_sum), 64'h1000);
        chk("bp_release_cnt",   64'(op_count), 64'd12);

        // Reset while holding a result (pointer currently 1)
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_cnt",   64'(op_count), 64'd0);
        chk("mid_rst_sum",   64'(res_sum), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ptr_ready", 64'(req_ready), 64'b0001);
        step();
        chk("mid_rst_first_id", 64'(res_id), 64'd0);
        chk("mid_rst_first_valid", 64'(res_valid), 64'd1);

        // Saturation: 21 further drains; the 4-bit counter stops at 15
        for (int k = 0; k < 21; k++) begin
            step();
        end
        chk("sat_cnt16", 64'(op_count), 64'd21);
        chk("sat_cnt4",  64'(op_count_s), 64'd15);
        chk("sat_valid", 64'(res_valid_s), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
